pipeline_hazard_controller: RTL

Central stall/flush controller for the 16-bit five-stage pipeline. It drives the `write_en`/`clear` pair of every pipeline register and the PC enable/select. It does this from three sources: hazard information in IF/ID and ID/EX, the branch/call/ret/run fields held in EX/MEM, and a data-memory ready handshake. Branch resolution happens here, in the MEM stage, using the EX/MEM flags V, Z and N.

---
 rtl/pipeline_hazard_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, MEM-stage
// branch/call/ret redirects, data-memory wait states and halt.
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ifid_Rs,
  input  logic [3:0]       ifid_Rt,
  input  logic             idex_MemRead,
  input  logic [3:0]       idex_Rd,
  input  logic             exmem_Branch,
  input  logic             exmem_call,
  input  logic             exmem_ret,
  input  logic [2:0]       exmem_BranchType,
  input  logic             exmem_V,
  input  logic             exmem_Z,
  input  logic             exmem_N,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             exmem_run,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ifid_en,
  output logic             ifid_clear,
  output logic             idex_en,
  output logic             idex_clear,
  output logic             exmem_en,
  output logic             exmem_clear,
  output logic             memwb_en,
  output logic             memwb_clear,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             take, redirect, mem_busy, load_use, mem_stall;

  always_comb begin
    case (exmem_BranchType)
      3'd0:    take = exmem_Z;
      3'd1:    take = !exmem_Z;
      3'd2:    take = !exmem_Z && (exmem_N == exmem_V);
      3'd3:    take = (exmem_N == exmem_V);
      3'd4:    take = (exmem_N != exmem_V);
      3'd5:    take = exmem_Z || (exmem_N != exmem_V);
      3'd6:    take = exmem_V;
      default: take = 1'b1;
    endcase
  end

  assign redirect = (exmem_Branch && take) || exmem_call || exmem_ret;
  assign mem_busy = (exmem_MemRead || exmem_MemWrite) && !mem_ready;
  assign load_use = idex_MemRead && (idex_Rd != 4'd0) &&
                    ((idex_Rd == ifid_Rs) || (idex_Rd == ifid_Rt));

  // Once waiting, only mem_ready releases the stall, whatever MEM now shows.
  assign mem_stall = (state_q == S_MEM_WAIT) ? !mem_ready : mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (mem_stall)       state_d = S_MEM_WAIT;
        else if (!exmem_run) state_d = S_HALT;
        else                 state_d = S_RUN;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    pc_sel      = 2'd0;
    ifid_en     = 1'b1;
    ifid_clear  = 1'b0;
    idex_en     = 1'b1;
    idex_clear  = 1'b0;
    exmem_en    = 1'b1;
    exmem_clear = 1'b0;
    memwb_en    = 1'b1;
    memwb_clear = 1'b0;
    halted      = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_clear  = 1'b1;
      idex_en     = 1'b0;
      idex_clear  = 1'b1;
      exmem_en    = 1'b0;
      exmem_clear = 1'b1;
      memwb_en    = 1'b0;
      memwb_clear = 1'b1;
    end else if (state_q == S_HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_clear = 1'b1;
    end else if (!exmem_run) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (redirect) begin
      // Flushed registers drop their enable so clear and enable never coincide.
      pc_sel      = exmem_ret ? 2'd2 : 2'd1;
      ifid_en     = 1'b0;
      ifid_clear  = 1'b1;
      idex_en     = 1'b0;
      idex_clear  = 1'b1;
      exmem_en    = 1'b0;
      exmem_clear = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      idex_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (!pc_en && (state_q != S_HALT) && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign stall_count = cnt_q;

endmodule
